meas_frame_sched: RTL
=====================

MEAS_FRAME_SCHED -- requirements
Module: meas_frame_sched

Interface
REQ-001 SHALL have parameter HDR, default 8'hA5, meaning the frame header byte.
REQ-002 SHALL have parameter TAIL, default 8'h5A, meaning the frame tail byte.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic SHALL run on this clock.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port tick, input, 1, meaning a one-cycle report strobe.
REQ-006 SHALL have ports pinlv, cycle and duty_cycle, each input, 32, meaning the frequency, period and duty measurement results.
REQ-007 SHALL have ports pinlv_vld, cycle_vld and duty_vld, each input, 1, meaning a one-cycle strobe that the matching result is new.
REQ-008 SHALL have port tx_data, output, 8, meaning the byte to the UART transmitter.
REQ-009 SHALL have port tx_start, output, 1, meaning a one-cycle pulse requesting transmission of tx_data.
REQ-010 SHALL have port tx_busy, input, 1, meaning the UART transmitter is sending.
REQ-011 SHALL have port frame_busy, output, 1, meaning a frame is in progress.
REQ-012 SHALL have port overrun, output, 1, meaning a one-cycle pulse when a tick is dropped.

Function
REQ-013 SHALL hold one 32-bit register and one pending flag per source; a vld strobe SHALL load the value and set the flag in any state.
REQ-014 SHALL implement states IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE and NEXT.
REQ-015 IDLE: on tick with at least one pending flag set, SHALL go to LOAD; on tick with no flag set, SHALL stay in IDLE and emit nothing.
REQ-016 LOAD: SHALL copy the holding registers to a snapshot, form mask = {duty, cycle, pinlv} pending bits, and clear the pending flags that were captured, all in one cycle.
REQ-017 If a vld strobe coincides with the LOAD cycle, the snapshot SHALL take the old value, and the new value SHALL load and its flag SHALL remain set for the next frame.
REQ-018 Frame byte order SHALL be: HDR, mask byte {5'b0, mask}, 4 bytes MSB-first for each set mask bit in order pinlv, cycle, duty_cycle, [checksum], TAIL.
REQ-019 SEND: SHALL drive tx_data and pulse tx_start for exactly one cycle, then go to WAIT_ACK.
REQ-020 WAIT_ACK: SHALL wait until tx_busy = 1, then go to WAIT_DONE; WAIT_DONE: SHALL wait until tx_busy = 0, then go to NEXT.
REQ-021 NEXT: SHALL advance the byte index, skipping unset sources, and return to SEND, or go to IDLE after TAIL.
REQ-022 Tick-to-first-tx_start latency SHALL be 2 cycles (tick at cycle n, LOAD at n+1, tx_start at n+2).
REQ-023 Any tick outside IDLE SHALL be ignored and SHALL pulse overrun in the same cycle.
REQ-024 frame_busy SHALL be 1 in every state except IDLE.
REQ-025 tx_data SHALL hold its value from the SEND cycle until the next SEND.
REQ-026 The frame length SHALL be 3 + 4 × popcount(mask) bytes, plus 1 when checksum is enabled; the maximum is 15 or 16 bytes.

Reset
REQ-027 rst SHALL asynchronously force IDLE, with tx_start=0, tx_data=8'h00, frame_busy=0, overrun=0, all pending flags, holding registers and snapshots 0, and the byte index 0.
REQ-028 rst asserted mid-frame SHALL abort the frame with no further tx_start; after release, a frame SHALL start only on a new tick.

Configuration
REQ-029 With FRAME_CHECKSUM_EN defined, a checksum byte SHALL be inserted before TAIL, equal to the XOR of the mask byte and all data bytes.
REQ-030 Without FRAME_CHECKSUM_EN, no checksum byte SHALL be sent and its logic SHALL be absent.

Verification
REQ-031 pinlv=32'h0001_86A0 with pinlv_vld, then tick, UART model busy 10 cycles per byte -> bytes A5 01 00 01 86 A0 5A (with macro: A5 01 00 01 86 A0 26 5A); first tx_start 2 cycles after tick.
REQ-032 All three vld strobes with values 32'h11223344, 32'h55667788, 32'h000000AA, then tick -> mask 07 and 12 data bytes in order pinlv, cycle, duty_cycle; frame_busy high throughout.
REQ-033 tick with no pending flags -> no tx_start, frame_busy stays 0.
REQ-034 tick during a frame -> overrun pulse 1 cycle, frame unchanged, no second frame.
REQ-035 cycle_vld with 32'h0000_0010 on the LOAD cycle, old value 32'h0000_0008 -> frame carries 08; next tick sends 10.
REQ-036 rst during the 5th byte -> outputs at reset values immediately, no further tx_start until a new tick.

Source files
------------

// File: rtl/meas_frame_sched.sv
// Measurement frame scheduler: snapshots pending results on tick and streams a framed packet to a UART.
// Optional checksum byte before the tail is enabled with the FRAME_CHECKSUM_EN macro.
module meas_frame_sched #(
    parameter logic [7:0] HDR  = 8'hA5,
    parameter logic [7:0] TAIL = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [31:0] pinlv,
    input  logic [31:0] cycle,
    input  logic [31:0] duty_cycle,
    input  logic        pinlv_vld,
    input  logic        cycle_vld,
    input  logic        duty_vld,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        frame_busy,
    output logic        overrun
);

    // IDLE wait tick | LOAD snapshot+mask | SEND tx_start pulse | WAIT_ACK busy rise
    // WAIT_DONE busy fall | NEXT advance slot or finish after TAIL
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_NEXT
    } state_t;

    localparam logic [3:0] SLOT_HDR   = 4'd0;
    localparam logic [3:0] SLOT_MASK  = 4'd1;
    localparam logic [3:0] SLOT_PINLV = 4'd2;
    localparam logic [3:0] SLOT_CYCLE = 4'd6;
    localparam logic [3:0] SLOT_DUTY  = 4'd10;
    localparam logic [3:0] SLOT_CHK   = 4'd14;
    localparam logic [3:0] SLOT_TAIL  = 4'd15;

    state_t      state_q;
    logic [31:0] hold_pinlv_q;
    logic [31:0] hold_cycle_q;
    logic [31:0] hold_duty_q;
    logic [2:0]  pend_q;
    logic [2:0]  pend_d;
    logic [31:0] snap_pinlv_q;
    logic [31:0] snap_cycle_q;
    logic [31:0] snap_duty_q;
    logic [2:0]  mask_q;
    logic [3:0]  idx_q;
    logic [3:0]  idx_d;
    logic [7:0]  byte_d;
    logic [3:0]  off_d;
    logic [31:0] word_d;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic [2:0]  vld_vec;

    function automatic logic [3:0] next_slot(input logic [3:0] cur, input logic [2:0] m);
        logic [3:0] n;
        n = cur + 4'd1;
        if (n == SLOT_PINLV && !m[0]) n = SLOT_CYCLE;
        if (n == SLOT_CYCLE && !m[1]) n = SLOT_DUTY;
        if (n == SLOT_DUTY  && !m[2]) n = SLOT_CHK;
`ifndef FRAME_CHECKSUM_EN
        if (n == SLOT_CHK) n = SLOT_TAIL;
`endif
        return n;
    endfunction

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] chk_d;

    function automatic logic [7:0] xor4(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    always_comb begin
        chk_d = {5'b0, mask_q};
        if (mask_q[0]) chk_d = chk_d ^ xor4(snap_pinlv_q);
        if (mask_q[1]) chk_d = chk_d ^ xor4(snap_cycle_q);
        if (mask_q[2]) chk_d = chk_d ^ xor4(snap_duty_q);
    end
`endif

    assign vld_vec = {duty_vld, cycle_vld, pinlv_vld};

    // Captured flags clear on LOAD, but a strobe in that same cycle re-arms its flag.
    assign pend_d = ((state_q == S_LOAD) ? 3'b000 : pend_q) | vld_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_pinlv_q <= 32'h0;
            hold_cycle_q <= 32'h0;
            hold_duty_q  <= 32'h0;
            pend_q       <= 3'b000;
        end else begin
            if (pinlv_vld) hold_pinlv_q <= pinlv;
            if (cycle_vld) hold_cycle_q <= cycle;
            if (duty_vld)  hold_duty_q  <= duty_cycle;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        idx_d  = next_slot(idx_q, mask_q);
        off_d  = idx_d - SLOT_PINLV;
        word_d = snap_duty_q;
        case (off_d[3:2])
            2'd0:    word_d = snap_pinlv_q;
            2'd1:    word_d = snap_cycle_q;
            default: word_d = snap_duty_q;
        endcase
        byte_d = word_d[31:24];
        case (off_d[1:0])
            2'd0:    byte_d = word_d[31:24];
            2'd1:    byte_d = word_d[23:16];
            2'd2:    byte_d = word_d[15:8];
            default: byte_d = word_d[7:0];
        endcase
        case (idx_d)
            SLOT_HDR:  byte_d = HDR;
            SLOT_MASK: byte_d = {5'b0, mask_q};
`ifdef FRAME_CHECKSUM_EN
            SLOT_CHK:  byte_d = chk_d;
`endif
            SLOT_TAIL: byte_d = TAIL;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            snap_pinlv_q <= 32'h0;
            snap_cycle_q <= 32'h0;
            snap_duty_q  <= 32'h0;
            mask_q       <= 3'b000;
            idx_q        <= SLOT_HDR;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tick && (|pend_q)) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    snap_pinlv_q <= hold_pinlv_q;
                    snap_cycle_q <= hold_cycle_q;
                    snap_duty_q  <= hold_duty_q;
                    mask_q       <= pend_q;
                    idx_q        <= SLOT_HDR;
                    tx_data_q    <= HDR;
                    tx_start_q   <= 1'b1;
                    state_q      <= S_SEND;
                end
                S_SEND: begin
                    state_q <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (tx_busy) state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (idx_q == SLOT_TAIL) begin
                        idx_q   <= SLOT_HDR;
                        state_q <= S_IDLE;
                    end else begin
                        idx_q      <= idx_d;
                        tx_data_q  <= byte_d;
                        tx_start_q <= 1'b1;
                        state_q    <= S_SEND;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign frame_busy = (state_q != S_IDLE);
    assign overrun    = tick && (state_q != S_IDLE);

endmodule
